// File: rtl/io_store_rmw_sequencer_pkg.sv
// Shared IO store definitions: sequencer state codes, store size codes and
// the native-size helper used by both the sequencer and the merge logic.
package io_store_rmw_sequencer_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t IDLE      = 3'd0;
    localparam seq_state_t READ_REQ  = 3'd1;
    localparam seq_state_t READ_WAIT = 3'd2;
    localparam seq_state_t WRITE     = 3'd3;
    localparam seq_state_t DONE_ERR  = 3'd4;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        WORD   = 2'd1,
        DOUBLE = 2'd2,
        QUAD   = 2'd3
    } store_size_t;

    // Size code of a full-width access on a bus of the given width.
    function automatic int native_size(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/io_store_rmw_sequencer_if.sv
// Store request, IO read and IO write channels of the store sequencer.
interface io_store_rmw_sequencer_if #(
    parameter int DATABITWIDTH = 16
);
    logic                    StoreValid;
    logic                    StoreReady;
    logic [3:0]              MinorOpcodeIn;
    logic [DATABITWIDTH-1:0] DataAddrIn;
    logic [DATABITWIDTH-1:0] DataIn;

    logic                    RdReqValid;
    logic                    RdReqReady;
    logic [DATABITWIDTH-1:0] RdReqAddr;
    logic                    RdRspValid;
    logic [DATABITWIDTH-1:0] RdRspData;

    logic                    WrReqValid;
    logic                    WrReqReady;
    logic [DATABITWIDTH-1:0] WrReqAddr;
    logic [DATABITWIDTH-1:0] WrReqData;

    logic                    StoreDone;
    logic                    StoreError;

    modport master (
        output StoreValid, MinorOpcodeIn, DataAddrIn, DataIn,
        output RdReqReady, RdRspValid, RdRspData, WrReqReady,
        input  StoreReady, RdReqValid, RdReqAddr,
        input  WrReqValid, WrReqAddr, WrReqData, StoreDone, StoreError
    );

    modport slave (
        input  StoreValid, MinorOpcodeIn, DataAddrIn, DataIn,
        input  RdReqReady, RdRspValid, RdRspData, WrReqReady,
        output StoreReady, RdReqValid, RdReqAddr,
        output WrReqValid, WrReqAddr, WrReqData, StoreDone, StoreError
    );
endinterface

// File: rtl/io_store_rmw_sequencer_merge.sv
// Byte-lane merge of a narrow store into a full-width read word; lanes are
// naturally aligned to the store size within the native word.
module io_store_merge
    import io_store_rmw_sequencer_pkg::*;
#(
    parameter int DATABITWIDTH = 16
) (
    input  logic [3:0]              opcode,
    input  logic [DATABITWIDTH-1:0] addr,
    input  logic [DATABITWIDTH-1:0] data,
    input  logic [DATABITWIDTH-1:0] rd_data,
    output logic [DATABITWIDTH-1:0] merged
);
    localparam int NBYTES = DATABITWIDTH / 8;
    localparam int NATIVE = native_size(DATABITWIDTH);

    int   size;
    int   lanes;
    int   offset;
    logic unused_bits;

    assign unused_bits = ^{opcode[3:2], addr[DATABITWIDTH-1:3]};

    always_comb begin
        size   = int'(opcode[1:0]);
        lanes  = 1 << size;
        offset = int'(addr[2:0]) & (NBYTES - 1) & ~(lanes - 1);
        merged = rd_data;
        if (size >= NATIVE) begin
            merged = data;
        end else begin
            for (int i = 0; i < NBYTES; i++) begin
                if (i >= offset && i < offset + lanes) begin
                    merged[8*i +: 8] = data[8*(i-offset) +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/io_store_rmw_sequencer.sv
// IO store sequencer: full-width stores are written directly, narrow stores
// become a read-modify-write of the aligned word, oversize stores error out.
module io_store_rmw_sequencer
    import io_store_rmw_sequencer_pkg::*;
#(
    parameter int DATABITWIDTH = 16
) (
    input  logic clk,
    input  logic async_rst,
    input  logic clk_en,
    io_store_rmw_sequencer_if.slave bus
);
    localparam int NBYTES = DATABITWIDTH / 8;
    localparam logic [1:0] NATIVE_CODE = 2'(native_size(DATABITWIDTH));
    localparam logic [DATABITWIDTH-1:0] LANE_MASK = DATABITWIDTH'(NBYTES - 1);

    seq_state_t              state_q, state_d;
    logic [3:0]              opcode_q, opcode_d;
    logic [DATABITWIDTH-1:0] addr_q, addr_d;
    logic [DATABITWIDTH-1:0] data_q, data_d;
    logic [DATABITWIDTH-1:0] wr_data_q, wr_data_d;
    logic                    rd_req_valid_q, rd_req_valid_d;
    logic                    wr_req_valid_q, wr_req_valid_d;
    logic                    store_done_q, store_done_d;
    logic                    store_error_q, store_error_d;
    logic                    store_ready;
    logic [DATABITWIDTH-1:0] merged;

    // Ready is withheld during a stall so no request is accepted and then lost.
    assign store_ready = (state_q == IDLE) && clk_en;

    io_store_merge #(
        .DATABITWIDTH(DATABITWIDTH)
    ) u_merge (
        .opcode  (opcode_q),
        .addr    (addr_q),
        .data    (data_q),
        .rd_data (bus.RdRspData),
        .merged  (merged)
    );

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        addr_d        = addr_q;
        data_d        = data_q;
        wr_data_d     = wr_data_q;
        store_done_d  = 1'b0;
        store_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.StoreValid && store_ready) begin
                    opcode_d = bus.MinorOpcodeIn;
                    addr_d   = bus.DataAddrIn;
                    data_d   = bus.DataIn;
                    if (bus.MinorOpcodeIn[1:0] == NATIVE_CODE) begin
                        wr_data_d = bus.DataIn;
                        state_d   = WRITE;
                    end else if (bus.MinorOpcodeIn[1:0] < NATIVE_CODE) begin
                        state_d = READ_REQ;
                    end else begin
                        state_d       = DONE_ERR;
                        store_done_d  = 1'b1;
                        store_error_d = 1'b1;
                    end
                end
            end
            READ_REQ: begin
                if (bus.RdReqReady) begin
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (bus.RdRspValid) begin
                    wr_data_d = merged;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (bus.WrReqReady) begin
                    store_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            DONE_ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Valids are registered copies of the next state so no input reaches them combinationally.
        rd_req_valid_d = (state_d == READ_REQ);
        wr_req_valid_d = (state_d == WRITE);
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q        <= IDLE;
            opcode_q       <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            wr_data_q      <= '0;
            rd_req_valid_q <= 1'b0;
            wr_req_valid_q <= 1'b0;
            store_done_q   <= 1'b0;
            store_error_q  <= 1'b0;
        end else if (clk_en) begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            wr_data_q      <= wr_data_d;
            rd_req_valid_q <= rd_req_valid_d;
            wr_req_valid_q <= wr_req_valid_d;
            store_done_q   <= store_done_d;
            store_error_q  <= store_error_d;
        end
    end

    assign bus.StoreReady = store_ready;
    assign bus.RdReqValid = rd_req_valid_q;
    assign bus.RdReqAddr  = addr_q & ~LANE_MASK;
    assign bus.WrReqValid = wr_req_valid_q;
    assign bus.WrReqAddr  = addr_q & ~LANE_MASK;
    assign bus.WrReqData  = wr_data_q;
    assign bus.StoreDone  = store_done_q;
    assign bus.StoreError = store_error_q;

endmodule

// File: tb/tb_io_store_rmw_sequencer.sv
// Randomized bench for the IO store sequencer at 16 and 32 bit widths,
// checked against a byte-mask arithmetic model of the store rules.
module tb_io_store_rmw_sequencer;
    import io_store_rmw_sequencer_pkg::*;

    logic clk = 1'b0;
    logic async_rst;
    logic clk_en;

    int checks = 0;
    int errors = 0;

    logic        sel32;
    logic        store_valid;
    logic [3:0]  opcode;
    logic [63:0] addr_in, data_in, rsp_data;
    logic        rd_req_ready, rsp_valid, wr_req_ready;

    logic        obs_store_ready, obs_rd_valid, obs_wr_valid, obs_done, obs_err;
    logic [63:0] obs_rd_addr, obs_wr_addr, obs_wr_data;

    io_store_rmw_sequencer_if #(.DATABITWIDTH(16)) bus16 ();
    io_store_rmw_sequencer_if #(.DATABITWIDTH(32)) bus32 ();

    io_store_rmw_sequencer #(.DATABITWIDTH(16)) dut16 (
        .clk       (clk),
        .async_rst (async_rst),
        .clk_en    (clk_en),
        .bus       (bus16.slave)
    );

    io_store_rmw_sequencer #(.DATABITWIDTH(32)) dut32 (
        .clk       (clk),
        .async_rst (async_rst),
        .clk_en    (clk_en),
        .bus       (bus32.slave)
    );

    always #5 clk = ~clk;

    // One set of stimulus variables steers whichever instance sel32 picks; the other sees idle inputs.
    assign bus16.StoreValid    = store_valid & ~sel32;
    assign bus16.MinorOpcodeIn = opcode;
    assign bus16.DataAddrIn    = addr_in[15:0];
    assign bus16.DataIn        = data_in[15:0];
    assign bus16.RdReqReady    = rd_req_ready & ~sel32;
    assign bus16.RdRspValid    = rsp_valid & ~sel32;
    assign bus16.RdRspData     = rsp_data[15:0];
    assign bus16.WrReqReady    = wr_req_ready & ~sel32;

    assign bus32.StoreValid    = store_valid & sel32;
    assign bus32.MinorOpcodeIn = opcode;
    assign bus32.DataAddrIn    = addr_in[31:0];
    assign bus32.DataIn        = data_in[31:0];
    assign bus32.RdReqReady    = rd_req_ready & sel32;
    assign bus32.RdRspValid    = rsp_valid & sel32;
    assign bus32.RdRspData     = rsp_data[31:0];
    assign bus32.WrReqReady    = wr_req_ready & sel32;

    assign obs_store_ready = sel32 ? bus32.StoreReady : bus16.StoreReady;
    assign obs_rd_valid    = sel32 ? bus32.RdReqValid : bus16.RdReqValid;
    assign obs_wr_valid    = sel32 ? bus32.WrReqValid : bus16.WrReqValid;
    assign obs_done        = sel32 ? bus32.StoreDone  : bus16.StoreDone;
    assign obs_err         = sel32 ? bus32.StoreError : bus16.StoreError;
    assign obs_rd_addr     = sel32 ? 64'(bus32.RdReqAddr) : 64'(bus16.RdReqAddr);
    assign obs_wr_addr     = sel32 ? 64'(bus32.WrReqAddr) : 64'(bus16.WrReqAddr);
    assign obs_wr_data     = sel32 ? 64'(bus32.WrReqData) : 64'(bus16.WrReqData);

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] width_mask(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    // 0 = direct write, 1 = read-modify-write, 2 = error
    function automatic int expected_kind(input int width, input logic [1:0] size);
        int native;
        native = $clog2(width / 8);
        if (int'(size) == native) return 0;
        if (int'(size) < native) return 1;
        return 2;
    endfunction

    function automatic logic [63:0] model_aligned(input int width, input logic [63:0] addr);
        return addr - (addr % 64'(width / 8));
    endfunction

    function automatic logic [63:0] model_merge(input int width, input logic [1:0] size,
                                                input logic [63:0] addr, input logic [63:0] data,
                                                input logic [63:0] rd);
        int           lanes;
        int           offset;
        logic [127:0] mask;
        logic [127:0] result;
        lanes  = 1 << size;
        offset = int'(addr % 64'(width / 8));
        offset = offset - (offset % lanes);
        mask   = ((128'd1 << (8 * lanes)) - 128'd1) << (8 * offset);
        result = ({64'd0, rd} & ~mask) | (({64'd0, data} << (8 * offset)) & mask);
        return result[63:0] & width_mask(width);
    endfunction

    // Runs one complete store on the selected instance, starting and ending at a falling edge.
    task automatic applyStimulus(input logic [1:0] size, input logic [63:0] addr,
                                 input logic [63:0] data, input logic [63:0] rd,
                                 input int rd_wait, input int rsp_wait, input int wr_wait,
                                 input bit stall_done);
        int          width;
        int          kind;
        logic [63:0] wmask;
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        width    = sel32 ? 32 : 16;
        wmask    = width_mask(width);
        kind     = expected_kind(width, size);
        exp_addr = model_aligned(width, addr & wmask);

        checkOutput("ready_idle", 64'(obs_store_ready), 64'd1);
        store_valid = 1'b1;
        opcode      = {2'($urandom), size};
        addr_in     = addr;
        data_in     = data;
        @(negedge clk);
        store_valid = 1'b0;
        addr_in     = {$urandom, $urandom};
        data_in     = {$urandom, $urandom};
        checkOutput("ready_busy", 64'(obs_store_ready), 64'd0);

        if (kind == 2) begin
            checkOutput("err_done", 64'(obs_done), 64'd1);
            checkOutput("err_flag", 64'(obs_err), 64'd1);
            checkOutput("err_no_rd", 64'(obs_rd_valid), 64'd0);
            checkOutput("err_no_wr", 64'(obs_wr_valid), 64'd0);
            @(negedge clk);
            checkOutput("err_done_clr", 64'(obs_done), 64'd0);
            checkOutput("err_ready", 64'(obs_store_ready), 64'd1);
            checkOutput("err_no_rd2", 64'(obs_rd_valid), 64'd0);
            checkOutput("err_no_wr2", 64'(obs_wr_valid), 64'd0);
            return;
        end

        if (kind == 1) begin
            for (int i = 0; i <= rd_wait; i++) begin
                checkOutput("rd_valid", 64'(obs_rd_valid), 64'd1);
                checkOutput("rd_addr", obs_rd_addr, exp_addr);
                checkOutput("rd_no_wr", 64'(obs_wr_valid), 64'd0);
                rd_req_ready = (i == rd_wait);
                @(negedge clk);
            end
            rd_req_ready = 1'b0;
            for (int i = 0; i <= rsp_wait; i++) begin
                checkOutput("wait_no_rd", 64'(obs_rd_valid), 64'd0);
                checkOutput("wait_no_wr", 64'(obs_wr_valid), 64'd0);
                rsp_valid = (i == rsp_wait);
                rsp_data  = (i == rsp_wait) ? rd : {$urandom, $urandom};
                @(negedge clk);
            end
            rsp_valid = 1'b0;
            rsp_data  = {$urandom, $urandom};
            exp_data  = model_merge(width, size, addr & wmask, data & wmask, rd & wmask);
        end else begin
            checkOutput("full_no_rd", 64'(obs_rd_valid), 64'd0);
            exp_data = data & wmask;
        end

        for (int i = 0; i <= wr_wait; i++) begin
            checkOutput("wr_valid", 64'(obs_wr_valid), 64'd1);
            checkOutput("wr_addr", obs_wr_addr, exp_addr);
            checkOutput("wr_data", obs_wr_data, exp_data);
            checkOutput("wr_no_done", 64'(obs_done), 64'd0);
            checkOutput("wr_ready_low", 64'(obs_store_ready), 64'd0);
            wr_req_ready = (i == wr_wait);
            @(negedge clk);
        end
        wr_req_ready = 1'b0;
        checkOutput("done", 64'(obs_done), 64'd1);
        checkOutput("done_err", 64'(obs_err), 64'd0);
        checkOutput("done_no_wr", 64'(obs_wr_valid), 64'd0);
        checkOutput("done_ready", 64'(obs_store_ready), 64'd1);
        if (stall_done) begin
            clk_en = 1'b0;
            @(negedge clk);
            checkOutput("done_held", 64'(obs_done), 64'd1);
            clk_en = 1'b1;
        end
        @(negedge clk);
        checkOutput("done_clr", 64'(obs_done), 64'd0);
    endtask

    initial begin
        async_rst    = 1'b1;
        clk_en       = 1'b1;
        sel32        = 1'b0;
        store_valid  = 1'b0;
        opcode       = '0;
        addr_in      = '0;
        data_in      = '0;
        rsp_data     = '0;
        rd_req_ready = 1'b0;
        rsp_valid    = 1'b0;
        wr_req_ready = 1'b0;

        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel32 = s[0];
            #1;
            checkOutput("rst_ready", 64'(obs_store_ready), 64'd1);
            checkOutput("rst_rd_valid", 64'(obs_rd_valid), 64'd0);
            checkOutput("rst_wr_valid", 64'(obs_wr_valid), 64'd0);
            checkOutput("rst_done", 64'(obs_done), 64'd0);
            checkOutput("rst_err", 64'(obs_err), 64'd0);
            checkOutput("rst_rd_addr", obs_rd_addr, 64'd0);
            checkOutput("rst_wr_addr", obs_wr_addr, 64'd0);
            checkOutput("rst_wr_data", obs_wr_data, 64'd0);
        end
        sel32 = 1'b0;
        @(negedge clk);
        async_rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed stores");
        applyStimulus(BYTE,   64'h0101, 64'h00AB, 64'h1234, 0, 0, 0, 1'b0);
        applyStimulus(WORD,   64'h0200, 64'hBEEF, 64'h0000, 0, 0, 0, 1'b0);
        applyStimulus(DOUBLE, 64'h0300, 64'h5555, 64'h0000, 0, 0, 0, 1'b0);
        applyStimulus(WORD,   64'h0402, 64'hCAFE, 64'h0000, 0, 0, 3, 1'b0);
        applyStimulus(BYTE,   64'h0100, 64'h00AB, 64'h1234, 2, 1, 1, 1'b1);
        sel32 = 1'b1;
        @(negedge clk);
        applyStimulus(BYTE,   64'h0003, 64'h005A, 64'h11223344, 0, 0, 0, 1'b0);
        applyStimulus(WORD,   64'h0006, 64'h9876, 64'hA1B2C3D4, 1, 0, 0, 1'b0);
        applyStimulus(QUAD,   64'h0010, 64'h1, 64'h0, 0, 0, 0, 1'b0);
        sel32 = 1'b0;
        @(negedge clk);

        $display("[TB] reset during read wait");
        store_valid = 1'b1;
        opcode      = {2'b00, BYTE};
        addr_in     = 64'h0101;
        data_in     = 64'h00AB;
        @(negedge clk);
        store_valid  = 1'b0;
        rd_req_ready = 1'b1;
        @(negedge clk);
        rd_req_ready = 1'b0;
        checkOutput("rw_no_rd", 64'(obs_rd_valid), 64'd0);
        #2 async_rst = 1'b1;
        #1;
        checkOutput("rw_rst_ready", 64'(obs_store_ready), 64'd1);
        checkOutput("rw_rst_no_wr", 64'(obs_wr_valid), 64'd0);
        @(negedge clk);
        async_rst = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 64'hFFFF;
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rw_after_ready", 64'(obs_store_ready), 64'd1);
            checkOutput("rw_after_no_wr", 64'(obs_wr_valid), 64'd0);
            checkOutput("rw_after_no_rd", 64'(obs_rd_valid), 64'd0);
            checkOutput("rw_after_no_done", 64'(obs_done), 64'd0);
            @(negedge clk);
        end

        $display("[TB] randomized stores");
        for (int n = 0; n < 80; n++) begin
            sel32 = 1'($urandom_range(1, 0));
            @(negedge clk);
            if ($urandom_range(2, 0) == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = {$urandom, $urandom};
                @(negedge clk);
                rsp_valid = 1'b0;
                checkOutput("idle_rsp_no_wr", 64'(obs_wr_valid), 64'd0);
                checkOutput("idle_rsp_ready", 64'(obs_store_ready), 64'd1);
            end
            applyStimulus(2'($urandom_range(3, 0)),
                          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                          $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                          ($urandom_range(3, 0) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_store_rmw_sequencer.md
IO_STORE_RMW_SEQUENCER -- requirements
Module: io_store_rmw_sequencer

Interface
REQ-001 SHALL have parameter DATABITWIDTH, default 16, meaning IO data and address width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port async_rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port clk_en  input  1  global stall; when low, all state and registered outputs hold.
REQ-005 SHALL have ports StoreValid input 1 / StoreReady output 1, the store request handshake.
REQ-006 SHALL have ports MinorOpcodeIn input 4 (bits[1:0] size: 0 byte, 1 16b, 2 32b, 3 64b), DataAddrIn input DATABITWIDTH, and DataIn input DATABITWIDTH.
REQ-007 SHALL have ports RdReqValid output 1, RdReqReady input 1, and RdReqAddr output DATABITWIDTH, the IO read request.
REQ-008 SHALL have ports RdRspValid input 1 and RdRspData input DATABITWIDTH, the IO read response, which has no backpressure.
REQ-009 SHALL have ports WrReqValid output 1, WrReqReady input 1, WrReqAddr output DATABITWIDTH, and WrReqData output DATABITWIDTH, the IO write request.
REQ-010 SHALL have ports StoreDone output 1 (one-cycle completion pulse) and StoreError output 1 (valid with StoreDone).

Function
REQ-011 SHALL define NATIVE = log2(DATABITWIDTH/8) and AlignedAddr = DataAddrIn with its low NATIVE bits cleared.
REQ-012 SHALL use the states IDLE, READ_REQ, READ_WAIT, WRITE and DONE_ERR, and SHALL assert StoreReady only in IDLE.
REQ-013 SHALL register opcode, address and data on a StoreValid&&StoreReady handshake, then transition to WRITE if size==NATIVE, READ_REQ if size<NATIVE, or DONE_ERR if size>NATIVE.
REQ-014 SHALL hold RdReqValid high in READ_REQ with RdReqAddr=AlignedAddr, and SHALL move to READ_WAIT on RdReqReady.
REQ-015 SHALL ignore RdRspValid outside READ_WAIT; in READ_WAIT, RdRspValid SHALL capture the merge of RdRspData with the stored data into a write register and move to WRITE.
REQ-016 SHALL preserve exactly the non-addressed bytes of the read word in the merge, with the addressed byte lane(s) taking DataIn's low bytes; a full-width store SHALL use DataIn unchanged.
REQ-017 SHALL hold WrReqValid high in WRITE, with WrReqAddr and WrReqData stable until WrReqReady; on handshake it SHALL pulse StoreDone (StoreError=0) and return to IDLE.
REQ-018 SHALL pulse StoreDone with StoreError=1 in DONE_ERR for one cycle, generate no bus traffic, and return to IDLE.
REQ-019 SHALL give latency, assuming zero-wait-state readies: full-width handshake to WrReqValid is 1 cycle; partial handshake to RdReqValid is 1 cycle and RdRspValid to WrReqValid is 1 cycle.
REQ-020 SHALL make StoreDone, WrReqValid and RdReqValid register-driven, with no combinational path from any input to them.
REQ-021 SHALL allow at most one store in flight, with no pipelining.

Reset
REQ-022 SHALL, on async_rst, force state to IDLE and all valid, done and error outputs to 0, and the address and data registers to 0.
REQ-023 SHALL abandon any transaction on reset mid-operation; a RdRspValid arriving after reset SHALL be ignored.

Structure
REQ-024 SHALL place the state enum and the size codes (BYTE, WORD, DOUBLE, QUAD) in the shared IO package.
REQ-025 SHALL instantiate the merge as one combinational sub-module, io_store_merge (opcode, address, data, read data -> merged word).

Verification
REQ-026 SHALL cover, at DATABITWIDTH=16, a byte store at address 0x0101 with data 0x00AB and read response 0x1234 -> RdReqAddr 0x0100, then WrReqAddr 0x0100 with WrReqData 0xAB34, and StoreDone=1 with StoreError=0.
REQ-027 SHALL cover a 16b store at address 0x0200 with data 0xBEEF -> no RdReqValid, and WrReqValid with 0xBEEF on the cycle after the handshake.
REQ-028 SHALL cover a size=2 store at 16b -> StoreDone=1 and StoreError=1, with no RdReqValid or WrReqValid ever asserted.
REQ-029 SHALL cover WrReqReady held low for 3 cycles -> WrReqValid, WrReqAddr and WrReqData stable, StoreReady=0, and StoreDone only after the handshake.
REQ-030 SHALL cover async_rst asserted in READ_WAIT, followed by RdRspValid with data 0xFFFF -> IDLE, StoreReady=1, and no write issued.
REQ-031 SHALL cover, at DATABITWIDTH=32, a byte store at address 0x3 with data 0x5A and read response 0x11223344 -> WrReqData 0x5A223344.
